// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the bypassing register file.
// No logic; state encoding for the clear sequencer lives here.
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int N_RD_DEF   = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: sweeps every address with a zero write after reset, one per cycle.
// busy is registered and stays high for exactly DEPTH cycles after reset release; no backpressure.
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_wa_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            CLEAR: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == '1) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
        // busy tracks the state being entered so it is a clean flop output
        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o   = busy_q;
    assign clr_we_o = (state_q == CLEAR);
    assign clr_wa_o = idx_q;

endmodule

// File: rtl/reg_file_bypass.sv
// Register file with N_RD async read lanes, write-to-read bypass and a post-reset clear sweep.
// Reads are combinational (0 cycles); writes land on the next edge and are dropped while busy.
module reg_file_bypass
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_RD     = N_RD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [N_RD*ADDR_W-1:0]   ra,
    output logic [N_RD*DATA_W-1:0]   rd,
    output logic                     busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_wa;
    logic              wa_is_zero;
    logic              user_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_q [DEPTH];

    reg_file_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .busy_o   (busy),
        .clr_we_o (clr_we),
        .clr_wa_o (clr_wa)
    );

    assign wa_is_zero = (ZERO_REG != 0) && (wa == '0);
    // A user write only counts when it will really land; bypass uses the same qualifier
    assign user_we    = we && !rst && !busy && !wa_is_zero;

    always_comb begin
        mem_we = clr_we || user_we;
        mem_wa = wa;
        mem_wd = wd;
        if (clr_we) begin
            mem_wa = clr_wa;
            mem_wd = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    for (genvar g = 0; g < N_RD; g++) begin : g_rd_lane
        logic [ADDR_W-1:0] lane_ra;
        logic [DATA_W-1:0] lane_rd;

        assign lane_ra = ra[g*ADDR_W +: ADDR_W];

        always_comb begin
            if (busy) begin
                lane_rd = '0;
            end else if ((ZERO_REG != 0) && (lane_ra == '0)) begin
                lane_rd = '0;
            end else if (user_we && (wa == lane_ra)) begin
                lane_rd = wd;
            end else begin
                lane_rd = mem_q[lane_ra];
            end
        end

        assign rd[g*DATA_W +: DATA_W] = lane_rd;
    end

endmodule

// File: tb/tb_reg_file_bypass.sv
// Directed bench for reg_file_bypass: default build plus a 16-bit/8-entry/4-lane build without zero register.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_reg_file_bypass;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration
    logic        rst_a, we_a, busy_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic [9:0]  ra_a;
    logic [63:0] rd_a;

    // DATA_W=16, ADDR_W=3, N_RD=4, ZERO_REG=0
    logic        rst_b, we_b, busy_b;
    logic [2:0]  wa_b;
    logic [15:0] wd_b;
    logic [11:0] ra_b;
    logic [63:0] rd_b;

    int checks = 0;
    int errors = 0;
    int n;

    reg_file_bypass u_dut_a (
        .clk  (clk),
        .rst  (rst_a),
        .we   (we_a),
        .wa   (wa_a),
        .wd   (wd_a),
        .ra   (ra_a),
        .rd   (rd_a),
        .busy (busy_a)
    );

    reg_file_bypass #(
        .DATA_W   (16),
        .ADDR_W   (3),
        .N_RD     (4),
        .ZERO_REG (0)
    ) u_dut_b (
        .clk  (clk),
        .rst  (rst_b),
        .we   (we_b),
        .wa   (wa_b),
        .wd   (wd_b),
        .ra   (ra_b),
        .rd   (rd_b),
        .busy (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic count_busy_a(output int cnt);
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 200) begin
            cnt++;
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic count_busy_b(output int cnt);
        cnt = 0;
        while (busy_b === 1'b1 && cnt < 200) begin
            cnt++;
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1; we_a = 1'b0; wa_a = '0; wd_a = '0; ra_a = '0;
        rst_b = 1'b1; we_b = 1'b0; wa_b = '0; wd_b = '0; ra_b = '0;

        // Reset sweep, default build
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy_a}, 32'd1);
        check("rst_rd0", rd_a[31:0], 32'h0);
        check("rst_rd1", rd_a[63:32], 32'h0);
        count_busy_a(n);
        check("sweep_len", n, 32'd32);
        for (int i = 0; i < 32; i++) begin
            ra_a = {5'(i), 5'(31 - i)};
            #1;
            check($sformatf("clr_r%0d", 31 - i), rd_a[31:0], 32'h0);
        end

        // Write then read back, zero register on the other lane
        @(negedge clk);
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        we_a = 1'b0; ra_a = {5'd0, 5'd5};
        #1;
        check("wr_r5", rd_a[31:0], 32'hDEADBEEF);
        check("wr_r0", rd_a[63:32], 32'h0);

        // Bypass on both lanes over an older value
        @(negedge clk);
        we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        wd_a = 32'h12345678; ra_a = {5'd7, 5'd7};
        #1;
        check("byp_l0", rd_a[31:0], 32'h12345678);
        check("byp_l1", rd_a[63:32], 32'h12345678);
        @(posedge clk);
        #1;
        check("byp_edge_l0", rd_a[31:0], 32'h12345678);
        @(negedge clk);
        we_a = 1'b0;
        #1;
        check("byp_arr_l0", rd_a[31:0], 32'h12345678);
        check("byp_arr_l1", rd_a[63:32], 32'h12345678);

        // Zero register wins over bypass; other lane unaffected
        @(negedge clk);
        we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFFFFFF; ra_a = {5'd5, 5'd0};
        #1;
        check("zr_same", rd_a[31:0], 32'h0);
        check("zr_other", rd_a[63:32], 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        we_a = 1'b0;
        #1;
        check("zr_after", rd_a[31:0], 32'h0);

        // Independent lanes: one bypasses, the other reads the array
        @(negedge clk);
        we_a = 1'b1; wa_a = 5'd9; wd_a = 32'hCAFEF00D; ra_a = {5'd5, 5'd9};
        #1;
        check("lane_byp", rd_a[31:0], 32'hCAFEF00D);
        check("lane_arr", rd_a[63:32], 32'hDEADBEEF);
        @(negedge clk);
        we_a = 1'b0;

        // Reset from READY, then reset again 10 cycles into the sweep
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h000000AA; ra_a = {5'd5, 5'd3};
        #1;
        check("busy_rd0", rd_a[31:0], 32'h0);
        check("busy_rd1", rd_a[63:32], 32'h0);
        count_busy_a(n);
        we_a = 1'b0;
        #1;
        check("midclr_len", n, 32'd32);
        check("drop_r3", rd_a[31:0], 32'h0);
        check("wipe_r5", rd_a[63:32], 32'h0);
        ra_a = {5'd9, 5'd7};
        #1;
        check("wipe_r7", rd_a[31:0], 32'h0);
        check("wipe_r9", rd_a[63:32], 32'h0);

        // Reduced build without a zero register
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        count_busy_b(n);
        check("b_sweep_len", n, 32'd8);
        we_b = 1'b1; wa_b = 3'd0; wd_b = 16'hBEEF; ra_b = '0;
        #1;
        check("b_byp_r0", {16'h0, rd_b[15:0]}, 32'h0000BEEF);
        @(posedge clk);
        @(negedge clk);
        we_b = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b_r0_l%0d", i), {16'h0, rd_b[i*16 +: 16]}, 32'h0000BEEF);
        end
        ra_b = {3'd1, 3'd2, 3'd3, 3'd4};
        #1;
        check("b_r4_clr", {16'h0, rd_b[15:0]}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_bypass.md
REG_FILE_BYPASS -- requirements
Module: reg_file_bypass

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter N_RD, default 2, giving the number of asynchronous read ports.
REQ-004 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads 0 and ignores writes.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port we, input, 1 bit: write enable.
REQ-008 The block SHALL have port wa, input, ADDR_W bits: write address.
REQ-009 The block SHALL have port wd, input, DATA_W bits: write data.
REQ-010 The block SHALL have port ra, input, N_RD*ADDR_W bits: packed read addresses, with port i at bits [i*ADDR_W +: ADDR_W].
REQ-011 The block SHALL have port rd, output, N_RD*DATA_W bits: packed read data, with port i at bits [i*DATA_W +: DATA_W].
REQ-012 The block SHALL have port busy, output, 1 bit: high while the array is being cleared.

Function
REQ-013 The state machine SHALL have two states: CLEAR and READY.
REQ-014 In CLEAR, each rising edge SHALL write 0 to mem[idx] and increment idx, where idx is an ADDR_W-bit counter.
REQ-015 When the write to idx == DEPTH-1 completes, CLEAR SHALL go to READY on that edge; idx wraps to 0.
REQ-016 busy SHALL be 1 in CLEAR and 0 in READY; busy is a registered output, not combinational.
REQ-017 The clear SHALL span exactly DEPTH cycles after the first edge with rst low.
REQ-018 While busy = 1, the we/wa/wd inputs SHALL be ignored (writes dropped, not queued), and every rd lane SHALL read 0.
REQ-019 In READY, a rising edge with we = 1 SHALL store wd into mem[wa], except wa == 0 when ZERO_REG = 1.
REQ-020 In READY, reads SHALL be asynchronous: rd lane i = mem[ra_i].
REQ-021 Lane i SHALL read 0 when ZERO_REG = 1 and ra_i == 0, regardless of bypass.
REQ-022 Bypass: in READY, if we = 1 and wa == ra_i (and the address is not the zero register), lane i SHALL present wd combinationally in the same cycle.
REQ-023 Bypass SHALL be evaluated independently per lane; multiple lanes may hit the same address simultaneously.
REQ-024 Bypass priority, highest first: busy-zero, then zero register, then bypass, then array.
REQ-025 Width rules: no truncation or extension; all data paths are exactly DATA_W bits.

Reset
REQ-026 With rst = 1 at a rising edge, state SHALL become CLEAR, idx SHALL become 0 and busy SHALL become 1.
REQ-027 With rst = 1, no write from we SHALL occur; the clear write to mem[0] is permitted.
REQ-028 Reset values: busy = 1, and all rd lanes = 0 until READY.
REQ-029 rst asserted mid-clear SHALL restart the sweep at idx 0, with the full DEPTH cycles repeated after release.
REQ-030 rst asserted in READY SHALL discard all array contents via a new sweep.
REQ-031 No asynchronous reset paths SHALL exist.

Structure
REQ-032 Package reg_file_pkg SHALL hold the state enum (CLEAR, READY) and the default values of DATA_W, ADDR_W and N_RD.
REQ-033 Sub-module reg_file_clr_seq SHALL contain the state register, the idx counter and busy, and SHALL output a clear-write strobe and address.
REQ-034 The array SHALL be a single DEPTH x DATA_W memory with one write port, muxed between the clear path and user writes.
REQ-035 The read lanes SHALL be built with a generate loop over N_RD.

Verification
REQ-036 Reset sweep: rst high 1 cycle, then low -> busy = 1 for exactly 32 cycles, then 0; all 32 registers read 0x00000000.
REQ-037 Write/read: write 0xDEADBEEF to r5; next cycle ra0 = 5 -> rd0 = 0xDEADBEEF; ra1 = 0 -> rd1 = 0.
REQ-038 Bypass: we = 1, wa = 7, wd = 0x12345678 with ra0 = ra1 = 7 in the same cycle -> both lanes show 0x12345678 before the edge; the old value is never visible.
REQ-039 Zero register: we = 1, wa = 0, wd = 0xFFFFFFFF -> rd for ra = 0 reads 0 both in that cycle and afterwards.
REQ-040 Mid-clear reset: rst at sweep cycle 10 -> idx restarts, busy lasts 32 more cycles, and a write attempted during busy (r3 = 0xAA) reads 0 after READY.
REQ-041 Parameter sweep: DATA_W = 16, ADDR_W = 3, N_RD = 4, ZERO_REG = 0 -> busy lasts 8 cycles, and a write of 0xBEEF to r0 reads back 0xBEEF on all four lanes.
